// File: rtl/sort_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// sort_pkg
// Shared definitions for the time-shared four-element sorter:
//   DIGIT_DEFAULT - default element width
//   NSTEP         - number of compare-exchange steps per job
//   state_t       - one-hot FSM state encoding
//   PAIR_LO_SCHED - lower element index of the pair used at each step
//   pair_lo()     - schedule lookup by step number
// ----------------------------------------------------------------------------
package sort_pkg;

    localparam int DIGIT_DEFAULT = 4;
    localparam int NSTEP         = 6;

    typedef enum logic [2:0] {
        IDLE = 3'b001,
        SORT = 3'b010,
        DONE = 3'b100
    } state_t;

    // Lower index of the compared pair, step k at bits [2k +: 2].
    // Steps 0..5 use pairs (0,1) (1,2) (2,3) (0,1) (1,2) (0,1).
    localparam logic [2*NSTEP-1:0] PAIR_LO_SCHED = {
        2'd0, // step 5
        2'd1, // step 4
        2'd0, // step 3
        2'd2, // step 2
        2'd1, // step 1
        2'd0  // step 0
    };

    function automatic logic [1:0] pair_lo(input logic [2:0] step);
        logic [1:0] idx;
        idx = 2'd0;
        if (int'(step) < NSTEP)
            idx = PAIR_LO_SCHED[2*int'(step) +: 2];
        return idx;
    endfunction

endpackage

// File: rtl/sort_arbiter_cmp_swap.sv
// ----------------------------------------------------------------------------
// cmp_swap
// Combinational unsigned compare-exchange of two elements.
//   a, b  in  DIGIT  operands (a is the lower-index element)
//   lo    out DIGIT  min(a, b)
//   hi    out DIGIT  max(a, b)
//   swap  out 1      a > b; equal operands never swap
// ----------------------------------------------------------------------------
module cmp_swap
    import sort_pkg::*;
#(
    parameter int DIGIT = DIGIT_DEFAULT
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic [DIGIT-1:0] lo,
    output logic [DIGIT-1:0] hi,
    output logic             swap
);

    always_comb begin
        swap = (a > b);
        lo   = swap ? b : a;
        hi   = swap ? a : b;
    end

endmodule

// File: rtl/sort_arbiter.sv
// ----------------------------------------------------------------------------
// sort_arbiter
// Two-requester sorting engine. A round-robin grant picks one job of four
// DIGIT-bit values, a fixed six-step compare-exchange schedule sorts it on a
// single cmp_swap unit, and the ascending result is returned with its
// requester id over a valid/ready handshake.
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   req0_valid  in   requester 0 has a job
//   req0_x      in   requester 0 values, element k at [k*DIGIT +: DIGIT]
//   req0_ready  out  requester 0 accepted when high with req0_valid
//   req1_valid  in   requester 1 has a job
//   req1_x      in   requester 1 values, same packing
//   req1_ready  out  requester 1 accept strobe
//   out_valid   out  sorted result available
//   out_ready   in   consumer takes the result
//   out_s       out  sorted ascending, element 0 smallest
//   out_id      out  requester owning out_s
//   busy        out  high whenever the engine is not idle
// ----------------------------------------------------------------------------
module sort_arbiter
    import sort_pkg::*;
#(
    parameter int DIGIT = DIGIT_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req0_valid,
    input  logic [4*DIGIT-1:0] req0_x,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic [4*DIGIT-1:0] req1_x,
    output logic               req1_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*DIGIT-1:0] out_s,
    output logic               out_id,
    output logic               busy
);

    state_t             state;
    logic [2:0]         step;
    logic [DIGIT-1:0]   r [4];
    logic               last_grant;

    logic               grant;
    logic               accept;
    logic [4*DIGIT-1:0] sel_x;

    logic [1:0]         lo_idx;
    logic [1:0]         hi_idx;
    logic [DIGIT-1:0]   cs_a;
    logic [DIGIT-1:0]   cs_b;
    logic [DIGIT-1:0]   cs_lo;
    logic [DIGIT-1:0]   cs_hi;
    logic               cs_swap;

    // Round-robin: a lone requester wins outright; on a tie the one that was
    // not served last wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign req0_ready = (state == IDLE) && !grant;
    assign req1_ready = (state == IDLE) &&  grant;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign sel_x      = grant ? req1_x : req0_x;

    // Single compare-swap unit, operands chosen by the step schedule.
    always_comb begin
        lo_idx = pair_lo(step);
        hi_idx = lo_idx + 2'd1;
        cs_a   = r[lo_idx];
        cs_b   = r[hi_idx];
    end

    cmp_swap #(
        .DIGIT(DIGIT)
    ) u_cmp_swap (
        .a    (cs_a),
        .b    (cs_b),
        .lo   (cs_lo),
        .hi   (cs_hi),
        .swap (cs_swap)
    );

    assign out_s = {r[3], r[2], r[1], r[0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            step       <= '0;
            for (int unsigned k = 0; k < 4; k++)
                r[k] <= '0;
            out_valid  <= 1'b0;
            out_id     <= 1'b0;
            last_grant <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        for (int unsigned k = 0; k < 4; k++)
                            r[k] <= sel_x[k*DIGIT +: DIGIT];
                        out_id     <= grant;
                        last_grant <= grant;
                        step       <= '0;
                        busy       <= 1'b1;
                        state      <= SORT;
                    end
                end
                SORT: begin
                    if (cs_swap) begin
                        r[lo_idx] <= cs_lo;
                        r[hi_idx] <= cs_hi;
                    end
                    if (step == 3'(NSTEP - 1)) begin
                        step      <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    step      <= '0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sort_arbiter.md
# sort_arbiter

Shared sorting engine that serves two requesters, each submitting four unsigned DIGIT-bit values. A round-robin arbiter picks one job at a time. A fixed six-step compare-exchange schedule drives a single compare-swap unit, and the result is returned with the requester id over a valid/ready handshake. The block sits between the two client front-ends and the output consumer, and replaces per-client sorters with one time-shared datapath.

## Interface
- DIGIT, 4, width of each element
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has a job
- req0_x  in  4*DIGIT  requester 0 values; element k at bits [k*DIGIT +: DIGIT]
- req0_ready  out  1  requester 0 job accepted this cycle when high with req0_valid
- req1_valid  in  1  requester 1 has a job
- req1_x  in  4*DIGIT  requester 1 values, same packing
- req1_ready  out  1  requester 1 accept strobe
- out_valid  out  1  sorted result available
- out_ready  in  1  consumer takes result
- out_s  out  4*DIGIT  sorted ascending; element 0 = smallest
- out_id  out  1  requester that owns out_s
- busy  out  1  high whenever state is not IDLE

## Operation
- States (one-hot): IDLE, SORT, DONE.
- IDLE: grant logic is combinational.
  - Only one reqN_valid high: grant that requester.
  - Both high: grant the requester other than last_grant.
  - reqN_ready = (state==IDLE) && grant==N. At most one ready is high per cycle.
- Accept (valid && ready at an edge):
  - Load r0..r3 from reqN_x.
  - out_id <= N, last_grant <= N, step <= 0.
  - Go to SORT.
- SORT: each cycle performs one compare-exchange on the pair given by step.
  - Schedule by step 0..5: (0,1), (1,2), (2,3), (0,1), (1,2), (0,1).
  - Swap only if lower-index element > higher-index element. Comparison is unsigned. Equal values are never swapped.
  - step increments each cycle. After step 5, go to DONE.
- DONE: out_valid=1 and out_s={r3,r2,r1,r0}.
  - out_s and out_id stay stable until out_valid && out_ready at an edge, then go to IDLE.
  - No new job is accepted in the DONE cycles or in the handshake cycle.
- reset (any time):
  - State goes to IDLE; step=0; r0..r3=0.
  - out_valid=0, out_id=0, last_grant=1, so req0 wins the first tie.
  - An in-flight job is discarded. Its requester must resubmit.
- reqN_x is sampled only at the accept edge. Later changes have no effect on the job.

## Timing
- Reset values: out_valid=0, out_s=0, out_id=0, busy=0. req0_ready/req1_ready follow the grant logic (combinational).
- Accept at edge E0. SORT steps occupy cycles E0..E5, step k in cycle E(k). out_valid rises after E6, giving 6-cycle accept-to-valid latency.
- With out_ready held high, DONE lasts 1 cycle. Back-to-back jobs are therefore accepted every 8 cycles.
- out_ready low stalls indefinitely in DONE. Pending requests wait and keep their valid high.
- Width: elements and compare are DIGIT bits. step is 3 bits (0..5). No arithmetic overflow is possible.

## Structure
- Package sort_pkg holds:
  - DIGIT default.
  - State encodings: IDLE=3'b001, SORT=3'b010, DONE=3'b100.
  - NSTEP=6.
  - Pair-schedule constants: lower index per step, 0,1,2,0,1,0.
- Sub-module cmp_swap (combinational). Inputs a, b (DIGIT). Outputs lo=min, hi=max, swap=(a>b).
  - One instance, fed through muxes selected by step.
- Top module contains: the FSM, the round-robin pointer, the element registers and the output handshake.

## Test plan
- Single job: req0 {x0..x3}={9,3,7,1} accepted; out_valid exactly 6 cycles later with out_s elements 0..3 = 1,3,7,9 and out_id=0.
- Tie and round-robin: both valid from reset. Order of service must be req0, req1, req0. req1 job {0,0,15,15} returns 0,0,15,15 with no swaps.
- Backpressure: out_ready low for 10 cycles. out_s/out_id must stay stable, busy=1, and both reqN_ready=0. Raise out_ready: IDLE next cycle.
- Reverse order: req1 {15,14,13,12} returns 12,13,14,15. Duplicates {5,2,5,2} return 2,2,5,5.
- Reset mid-sort: assert reset at step 3. Next cycle out_valid=0, busy=0, and the resubmitted job sorts correctly from a fresh start.
- Input change after accept: alter req0_x on the cycle after accept. The result must reflect only the values sampled at the accept edge.
